// File: rtl/proc_instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: instruction field layout,
// opcode values and the sequencer FSM state encoding.
package proc_instr_sequencer_pkg;

  // Instruction word layout: IIIXXXYYY
  localparam int unsigned INSTR_W = 9;
  localparam int unsigned OP_MSB  = 8;
  localparam int unsigned OP_LSB  = 6;

  typedef enum logic [2:0] {
    OpMv   = 3'b000,
    OpMvi  = 3'b001,
    OpAdd  = 3'b010,
    OpSub  = 3'b011,
    OpHalt = 3'b111
  } opcode_e;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StFetchImm,
    StIssue,
    StExec,
    StError
  } seq_state_e;

  function automatic logic [2:0] opcode(input logic [INSTR_W-1:0] instr);
    return instr[OP_MSB:OP_LSB];
  endfunction

endpackage

// File: rtl/proc_instr_sequencer_timer.sv
// Done-wait timer for the instruction sequencer.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : synchronously reload the count with zero (wins over en)
//   en         : count up by one per cycle
//   terminal   : high in the cycle whose closing edge brings the count to TIMEOUT
module proc_instr_sequencer_timer #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic terminal
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  logic [CntW-1:0] count;

  assign terminal = en && (count == CntW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en && !terminal) begin
      // Hold at the limit instead of wrapping.
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/proc_instr_sequencer.sv
// Autonomous instruction feeder for the 9-bit simple processor. Reads a synchronous
// program ROM, issues each instruction on DIN with a one-cycle Run pulse (mvi immediate
// follows on DIN), waits for Done and advances the PC.
// Ports:
//   Clock, Resetn : clock, asynchronous active-low reset
//   Start         : pulse, restart at address 0 (honoured in IDLE/ERROR only)
//   Stop          : level, return to IDLE after the current instruction's Done
//   mem_addr      : ROM address (data appears on mem_data one cycle later)
//   mem_data      : ROM read data
//   DIN, Run      : processor instruction/immediate bus and issue strobe
//   Done          : processor completion
//   Busy          : high outside IDLE and ERROR
//   PC            : address of the current instruction
//   instr_cnt     : completed instructions since Start, saturating at 255
//   Error         : sticky Done timeout flag
module proc_instr_sequencer
  import proc_instr_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned TIMEOUT = 15,
  parameter logic [2:0]  HALT_OP = OpHalt
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Start,
  input  logic              Stop,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [8:0]        mem_data,
  output logic [8:0]        DIN,
  output logic              Run,
  input  logic              Done,
  output logic              Busy,
  output logic [ADDR_W-1:0] PC,
  output logic [7:0]        instr_cnt,
  output logic              Error
);

  seq_state_e        state;
  logic [8:0]        ir;
  logic [8:0]        imm;
  logic [2:0]        dec_op;
  logic              ir_is_mvi;
  logic [ADDR_W-1:0] pc_next;
  logic              timer_active;
  logic              timer_terminal;

  assign dec_op       = opcode(mem_data);
  assign ir_is_mvi    = (opcode(ir) == OpMvi);
  // Modulo 2**ADDR_W, so the wrap from the last address is implicit.
  assign pc_next      = PC + (ir_is_mvi ? ADDR_W'(2) : ADDR_W'(1));
  assign timer_active = (state == StIssue) || (state == StExec);

  proc_instr_sequencer_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk      (Clock),
    .rst_n    (Resetn),
    .clear    (!timer_active),
    .en       (timer_active),
    .terminal (timer_terminal)
  );

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state     <= StIdle;
      mem_addr  <= '0;
      DIN       <= '0;
      Run       <= 1'b0;
      Busy      <= 1'b0;
      PC        <= '0;
      instr_cnt <= '0;
      Error     <= 1'b0;
      ir        <= '0;
      imm       <= '0;
    end else begin
      Run <= 1'b0;
      case (state)
        StIdle, StError: begin
          if (Start) begin
            state     <= StFetch;
            PC        <= '0;
            mem_addr  <= '0;
            instr_cnt <= '0;
            Error     <= 1'b0;
            Busy      <= 1'b1;
          end
        end
        StFetch: begin
          // Instruction address is already with the ROM; pre-point at the word after it
          // so an mvi immediate is ready one cycle after DECODE.
          mem_addr <= PC + ADDR_W'(1);
          state    <= StDecode;
        end
        StDecode: begin
          ir <= mem_data;
          if (dec_op == HALT_OP) begin
            state <= StIdle;
            Busy  <= 1'b0;
          end else if (dec_op == OpMvi) begin
            state <= StFetchImm;
          end else begin
            state <= StIssue;
            Run   <= 1'b1;
            DIN   <= mem_data;
          end
        end
        StFetchImm: begin
          imm   <= mem_data;
          state <= StIssue;
          Run   <= 1'b1;
          DIN   <= ir;
        end
        StIssue: begin
          state <= StExec;
          DIN   <= ir_is_mvi ? imm : ir;
        end
        StExec: begin
          // Done is checked first so it wins over a same-cycle timeout.
          if (Done) begin
            PC <= pc_next;
            if (instr_cnt != 8'hFF) begin
              instr_cnt <= instr_cnt + 8'd1;
            end
            if (Stop) begin
              state <= StIdle;
              Busy  <= 1'b0;
            end else begin
              state    <= StFetch;
              mem_addr <= pc_next;
            end
          end else if (timer_terminal) begin
            state <= StError;
            Error <= 1'b1;
            Busy  <= 1'b0;
          end
        end
        default: begin
          state <= StIdle;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_proc_instr_sequencer.sv
// Directed bench for proc_instr_sequencer with a synchronous ROM and a small
// behavioural model of the 9-bit processor (mv/mvi/add/sub, programmable Done delay).
module tb_proc_instr_sequencer;

  logic       Clock;
  logic       Resetn;
  logic       Start;
  logic       Stop;
  logic [4:0] mem_addr;
  logic [8:0] mem_data;
  logic [8:0] DIN;
  logic       Run;
  logic       Done;
  logic       Busy;
  logic [4:0] PC;
  logic [7:0] instr_cnt;
  logic       Error;

  int n_cmp = 0;
  int n_err = 0;
  int run_cnt = 0;
  int run_base;
  int done_dly;

  logic [8:0] rom   [32];
  logic [8:0] p_reg [8];
  logic [8:0] p_ir;
  int         p_cnt;

  proc_instr_sequencer dut (
    .Clock     (Clock),
    .Resetn    (Resetn),
    .Start     (Start),
    .Stop      (Stop),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .DIN       (DIN),
    .Run       (Run),
    .Done      (Done),
    .Busy      (Busy),
    .PC        (PC),
    .instr_cnt (instr_cnt),
    .Error     (Error)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Synchronous program ROM
  always @(posedge Clock) mem_data <= rom[mem_addr];

  always @(posedge Clock) if (Run) run_cnt <= run_cnt + 1;

  // Processor model: latch instruction on Run, raise Done done_dly cycles into EXEC
  // (done_dly == 0 means never), execute using DIN (the immediate for mvi) at that point.
  always @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      Done  <= 1'b0;
      p_cnt <= 0;
      p_ir  <= '0;
      for (int k = 0; k < 8; k++) p_reg[k] <= '0;
    end else begin
      Done <= 1'b0;
      if (Run) begin
        p_ir  <= DIN;
        p_cnt <= done_dly;
      end else if (p_cnt == 1) begin
        Done  <= 1'b1;
        p_cnt <= 0;
        case (p_ir[8:6])
          3'b000:  p_reg[p_ir[5:3]] <= p_reg[p_ir[2:0]];
          3'b001:  p_reg[p_ir[5:3]] <= DIN;
          3'b010:  p_reg[p_ir[5:3]] <= p_reg[p_ir[5:3]] + p_reg[p_ir[2:0]];
          3'b011:  p_reg[p_ir[5:3]] <= p_reg[p_ir[5:3]] - p_reg[p_ir[2:0]];
          default: ;
        endcase
      end else if (p_cnt != 0) begin
        p_cnt <= p_cnt - 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge Clock);
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    for (int k = 0; k < max; k++) begin
      @(negedge Clock);
      if (!Busy) break;
    end
  endtask

  task automatic wait_cnt(input int target, input int max);
    for (int k = 0; k < max; k++) begin
      @(negedge Clock);
      if (instr_cnt == 8'(target)) break;
    end
  endtask

  initial begin
    Resetn   = 1'b0;
    Start    = 1'b0;
    Stop     = 1'b0;
    done_dly = 2;
    for (int k = 0; k < 32; k++) rom[k] = 9'h1C0;
    tick(2);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_din", DIN, 0);
    check("rst_run", Run, 0);
    check("rst_busy", Busy, 0);
    check("rst_pc", PC, 0);
    check("rst_cnt", instr_cnt, 0);
    check("rst_error", Error, 0);
    Resetn = 1'b1;
    tick(1);

    // mvi R0,5; mvi R1,3; add R0,R1; halt
    rom[0] = 9'h040; rom[1] = 9'h005; rom[2] = 9'h048; rom[3] = 9'h003;
    rom[4] = 9'h081; rom[5] = 9'h1C0;
    run_base = run_cnt;
    pulse_start();
    check("t1_fetch_busy", Busy, 1);
    check("t1_fetch_addr", mem_addr, 0);
    tick(1);
    check("t1_decode_run", Run, 0);
    tick(1);
    check("t1_fimm_run", Run, 0);
    tick(1);
    check("t1_issue_run", Run, 1);
    check("t1_issue_din", DIN, 9'h040);
    tick(1);
    check("t1_exec_run", Run, 0);
    check("t1_exec_din_imm", DIN, 9'h005);
    wait_idle(200);
    check("t1_busy", Busy, 0);
    check("t1_runs", run_cnt - run_base, 3);
    check("t1_cnt", instr_cnt, 3);
    check("t1_pc", PC, 5);
    check("t1_r0", p_reg[0], 8);

    // mvi R2,0x1FF; mv R3,R2; sub R3,R2; halt
    rom[0] = 9'h050; rom[1] = 9'h1FF; rom[2] = 9'h01A; rom[3] = 9'h0DA; rom[4] = 9'h1C0;
    pulse_start();
    tick(4);
    check("t2_exec_din_imm", DIN, 9'h1FF);
    wait_idle(200);
    check("t2_busy", Busy, 0);
    check("t2_r2", p_reg[2], 9'h1FF);
    check("t2_r3", p_reg[3], 0);
    check("t2_pc", PC, 4);
    check("t2_cnt", instr_cnt, 3);

    // Timeout: Done never arrives
    rom[0] = 9'h081; rom[1] = 9'h1C0;
    done_dly = 0;
    pulse_start();
    tick(2);
    check("t3_issue_run", Run, 1);
    tick(14);
    check("t3_err_early", Error, 0);
    check("t3_busy_early", Busy, 1);
    tick(1);
    check("t3_err", Error, 1);
    check("t3_busy", Busy, 0);
    check("t3_run", Run, 0);
    check("t3_cnt", instr_cnt, 0);
    done_dly = 2;
    pulse_start();
    check("t3_restart_err", Error, 0);
    check("t3_restart_busy", Busy, 1);
    check("t3_restart_addr", mem_addr, 0);
    wait_idle(100);
    check("t3_restart_cnt", instr_cnt, 1);
    check("t3_restart_pc", PC, 1);

    // Done on the last allowed cycle wins; one cycle later is too late
    done_dly = 13;
    pulse_start();
    wait_idle(100);
    check("t3_edge_err", Error, 0);
    check("t3_edge_cnt", instr_cnt, 1);
    done_dly = 14;
    pulse_start();
    wait_idle(100);
    tick(3);
    check("t3_late_err", Error, 1);
    check("t3_late_cnt", instr_cnt, 0);
    check("t3_late_busy", Busy, 0);

    // Stop during EXEC of the second instruction
    rom[0] = 9'h081; rom[1] = 9'h081; rom[2] = 9'h081; rom[3] = 9'h1C0;
    done_dly = 2;
    run_base = run_cnt;
    pulse_start();
    tick(9);
    check("t4_runs_mid", run_cnt - run_base, 2);
    Stop = 1'b1;
    tick(3);
    check("t4_busy", Busy, 0);
    check("t4_cnt", instr_cnt, 2);
    check("t4_pc", PC, 2);
    tick(10);
    check("t4_runs_end", run_cnt - run_base, 2);
    Stop = 1'b0;

    // No halt: PC wraps and instr_cnt saturates
    for (int k = 0; k < 32; k++) rom[k] = 9'h081;
    done_dly = 1;
    pulse_start();
    wait_cnt(31, 400);
    check("t5_pc31", PC, 31);
    wait_cnt(32, 50);
    check("t5_pc_wrap", PC, 0);
    wait_cnt(255, 2000);
    check("t5_cnt255", instr_cnt, 255);
    tick(20);
    check("t5_cnt_sat", instr_cnt, 255);
    check("t5_busy", Busy, 1);
    Stop = 1'b1;
    wait_idle(20);
    check("t5_stop_busy", Busy, 0);
    check("t5_stop_cnt", instr_cnt, 255);
    Stop = 1'b0;

    // mvi at the last address takes its immediate from address 0
    for (int k = 0; k < 31; k++) rom[k] = 9'h02D;
    rom[31] = 9'h060;
    pulse_start();
    wait_cnt(31, 400);
    check("t6_pc31", PC, 31);
    wait_cnt(32, 50);
    check("t6_pc_wrap", PC, 1);
    check("t6_r4", p_reg[4], 9'h02D);
    Stop = 1'b1;
    wait_idle(50);
    check("t6_busy", Busy, 0);
    check("t6_cnt", instr_cnt, 33);
    check("t6_pc", PC, 2);
    Stop = 1'b0;

    // Reset asserted during FETCH_IMM
    rom[0] = 9'h040; rom[1] = 9'h005; rom[2] = 9'h048; rom[3] = 9'h003;
    rom[4] = 9'h081; rom[5] = 9'h1C0;
    done_dly = 2;
    pulse_start();
    tick(2);
    check("t7_pre_busy", Busy, 1);
    check("t7_pre_addr", mem_addr, 1);
    Resetn = 1'b0;
    #1;
    check("t7_addr", mem_addr, 0);
    check("t7_din", DIN, 0);
    check("t7_pc", PC, 0);
    check("t7_cnt", instr_cnt, 0);
    check("t7_run", Run, 0);
    check("t7_busy", Busy, 0);
    check("t7_err", Error, 0);
    @(negedge Clock);
    Resetn = 1'b1;
    tick(5);
    check("t7_after_busy", Busy, 0);
    check("t7_after_run", Run, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
